// File: rtl/shift_reg_universal.sv
// Universal shift register with hold, shift right, shift left and parallel
// load, each shift optionally a rotate. A saturating counter tracks shifts
// since the last load or reset and fires a one-cycle done pulse on the
// WIDTH-th shift. Every output comes from a register, so there is no
// combinational path from any input to any output.
module shift_reg_universal #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic                       rot,
    input  logic                       sdi_r,
    input  logic                       sdi_l,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           q,
    output logic                       sdo_r,
    output logic                       sdo_l,
    output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
    output logic                       done
);

    localparam int CW = $clog2(WIDTH+1);

    // The counter saturates at WIDTH. The pulse fires on the shift that
    // takes the counter from WIDTH-1 to WIDTH.
    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_RIGHT = 2'b01,
        MODE_LEFT  = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_t;

    generate
        if (WIDTH < 2) begin : g_width_check
            $error("shift_reg_universal: WIDTH must be at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] q_next;
    logic [CW-1:0]    cnt_next;
    logic             done_next;
    logic             shifting;
    logic             in_r;
    logic             in_l;

    // Bits entering on each side: the wrapped-around bit when rotating,
    // otherwise the serial input for that direction.
    always_comb begin
        in_r = rot ? q[0]       : sdi_r;
        in_l = rot ? q[WIDTH-1] : sdi_l;
    end

    // Next-state selection for data, shift counter and done pulse.
    always_comb begin
        q_next    = q;
        cnt_next  = shift_cnt;
        done_next = 1'b0;
        shifting  = 1'b0;

        if (en) begin
            case (mode_t'(mode))
                MODE_RIGHT: begin
                    q_next   = {in_r, q[WIDTH-1:1]};
                    shifting = 1'b1;
                end
                MODE_LEFT: begin
                    q_next   = {q[WIDTH-2:0], in_l};
                    shifting = 1'b1;
                end
                MODE_LOAD: begin
                    q_next   = din;
                    cnt_next = '0;
                end
                default: begin
                end
            endcase
        end

        // Both directions count. A change of direction leaves the count
        // alone; only a load or a reset restarts it.
        if (shifting) begin
            if (shift_cnt != CNT_MAX) begin
                cnt_next = shift_cnt + CW'(1);
            end
            done_next = (shift_cnt == CNT_LAST);
        end
    end

    // State register. The reset is asynchronous and can arrive at any time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q         <= RESET_VAL;
            shift_cnt <= '0;
            done      <= 1'b0;
        end else begin
            q         <= q_next;
            shift_cnt <= cnt_next;
            done      <= done_next;
        end
    end

    // The serial outputs tap the register ends directly, with no added latency.
    always_comb begin
        sdo_r = q[0];
        sdo_l = q[WIDTH-1];
    end

endmodule

// File: tb/tb_shift_reg_universal.sv
// Self-checking bench for shift_reg_universal (WIDTH=8, RESET_VAL=0).
// It runs a table of directed vectors, then hand-written asynchronous-reset
// sequences, then randomized traffic compared against a behavioural model.
module tb_shift_reg_universal;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       en    = 1'b0;
    logic [1:0] mode  = 2'b00;
    logic       rot   = 1'b0;
    logic       sdi_r = 1'b0;
    logic       sdi_l = 1'b0;
    logic [7:0] din   = 8'h00;
    logic [7:0] q;
    logic       sdo_r;
    logic       sdo_l;
    logic [3:0] shift_cnt;
    logic       done;

    int checks = 0;
    int errors = 0;

    shift_reg_universal #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .rot       (rot),
        .sdi_r     (sdi_r),
        .sdi_l     (sdi_l),
        .din       (din),
        .q         (q),
        .sdo_r     (sdo_r),
        .sdo_l     (sdo_l),
        .shift_cnt (shift_cnt),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic       rot;
        logic       sdi_r;
        logic       sdi_l;
        logic [7:0] din;
        logic [7:0] exp_q;
        logic [3:0] exp_cnt;
        logic       exp_done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic e, logic [1:0] m, logic r, logic sr, logic sl,
                                logic [7:0] d, logic [7:0] eq, logic [3:0] ec, logic ed);
        vec_t v;
        v.en = e; v.mode = m; v.rot = r; v.sdi_r = sr; v.sdi_l = sl; v.din = d;
        v.exp_q = eq; v.exp_cnt = ec; v.exp_done = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] eq, input logic [3:0] ec,
                             input logic ed);
        check({tag, ".q"},     32'(q),         32'(eq));
        check({tag, ".cnt"},   32'(shift_cnt), 32'(ec));
        check({tag, ".done"},  32'(done),      32'(ed));
        check({tag, ".sdo_r"}, 32'(sdo_r),     32'(eq[0]));
        check({tag, ".sdo_l"}, 32'(sdo_l),     32'(eq[7]));
    endtask

    task automatic drive(input logic e, input logic [1:0] m, input logic r, input logic sr,
                         input logic sl, input logic [7:0] d);
        en = e; mode = m; rot = r; sdi_r = sr; sdi_l = sl; din = d;
    endtask

    // Apply the current inputs on one edge, then step clear of it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference: total shifts since the last load or reset, unclamped.
    logic [7:0] m_q;
    int         m_shifts;
    logic       m_done;

    task automatic model_edge(input logic e, input logic [1:0] m, input logic r,
                              input logic sr, input logic sl, input logic [7:0] d);
        int b;
        m_done = 1'b0;
        if (e) begin
            if (m == 2'b11) begin
                m_q = d;
                m_shifts = 0;
            end else if (m == 2'b01) begin
                b = r ? int'(m_q % 2) : int'(sr);
                m_q = 8'((int'(m_q) / 2) + b * 128);
                m_shifts++;
                m_done = (m_shifts == 8);
            end else if (m == 2'b10) begin
                b = r ? int'(m_q / 128) : int'(sl);
                m_q = 8'(((int'(m_q) * 2) % 256) + b);
                m_shifts++;
                m_done = (m_shifts == 8);
            end
        end
    endtask

    initial begin
        logic [7:0] tq;
        logic [7:0] rq;
        logic       re;
        logic [1:0] rm;
        logic       rr;
        logic       rsr;
        logic       rsl;
        logic [7:0] rd;
        int         sel;

        // Reset is applied and checked before the first clock edge.
        #1 reset = 1'b1;
        #1;
        check_all("reset_async", 8'h00, 4'd0, 1'b0);
        #1 reset = 1'b0;
        tick();
        check_all("reset_release", 8'h00, 4'd0, 1'b0);

        // Load A5, then eight plain right shifts with zeros entering.
        vecs.push_back(mk(1, 2'b11, 0, 0, 0, 8'hA5, 8'hA5, 4'd0, 0));
        tq = 8'hA5;
        for (int i = 1; i <= 8; i++) begin
            tq = tq >> 1;
            vecs.push_back(mk(1, 2'b01, 0, 0, 0, 8'h00, tq, 4'(i), i == 8));
        end
        // Load 81, then nine left rotates. The serial inputs are 1 to prove they are ignored.
        vecs.push_back(mk(1, 2'b11, 0, 0, 0, 8'h81, 8'h81, 4'd0, 0));
        vecs.push_back(mk(1, 2'b10, 1, 1, 1, 8'h00, 8'h03, 4'd1, 0));
        vecs.push_back(mk(1, 2'b10, 1, 1, 1, 8'h00, 8'h06, 4'd2, 0));
        vecs.push_back(mk(1, 2'b10, 1, 1, 1, 8'h00, 8'h0C, 4'd3, 0));
        vecs.push_back(mk(1, 2'b10, 1, 1, 1, 8'h00, 8'h18, 4'd4, 0));
        vecs.push_back(mk(1, 2'b10, 1, 1, 1, 8'h00, 8'h30, 4'd5, 0));
        vecs.push_back(mk(1, 2'b10, 1, 1, 1, 8'h00, 8'h60, 4'd6, 0));
        vecs.push_back(mk(1, 2'b10, 1, 1, 1, 8'h00, 8'hC0, 4'd7, 0));
        vecs.push_back(mk(1, 2'b10, 1, 1, 1, 8'h00, 8'h81, 4'd8, 1));
        vecs.push_back(mk(1, 2'b10, 1, 1, 1, 8'h00, 8'h03, 4'd8, 0));
        // Load 00, four left shifts with ones entering, then en=0 and a hold.
        vecs.push_back(mk(1, 2'b11, 0, 0, 0, 8'h00, 8'h00, 4'd0, 0));
        vecs.push_back(mk(1, 2'b10, 0, 0, 1, 8'h00, 8'h01, 4'd1, 0));
        vecs.push_back(mk(1, 2'b10, 0, 0, 1, 8'h00, 8'h03, 4'd2, 0));
        vecs.push_back(mk(1, 2'b10, 0, 0, 1, 8'h00, 8'h07, 4'd3, 0));
        vecs.push_back(mk(1, 2'b10, 0, 0, 1, 8'h00, 8'h0F, 4'd4, 0));
        vecs.push_back(mk(0, 2'b10, 0, 0, 1, 8'h55, 8'h0F, 4'd4, 0));
        vecs.push_back(mk(0, 2'b11, 0, 0, 1, 8'h55, 8'h0F, 4'd4, 0));
        vecs.push_back(mk(0, 2'b01, 0, 1, 1, 8'h55, 8'h0F, 4'd4, 0));
        vecs.push_back(mk(1, 2'b00, 0, 1, 1, 8'h55, 8'h0F, 4'd4, 0));
        // Load FF, three right shifts then five left shifts. Both directions count.
        vecs.push_back(mk(1, 2'b11, 0, 0, 0, 8'hFF, 8'hFF, 4'd0, 0));
        vecs.push_back(mk(1, 2'b01, 0, 0, 0, 8'h00, 8'h7F, 4'd1, 0));
        vecs.push_back(mk(1, 2'b01, 0, 0, 0, 8'h00, 8'h3F, 4'd2, 0));
        vecs.push_back(mk(1, 2'b01, 0, 0, 0, 8'h00, 8'h1F, 4'd3, 0));
        vecs.push_back(mk(1, 2'b10, 0, 0, 0, 8'h00, 8'h3E, 4'd4, 0));
        vecs.push_back(mk(1, 2'b10, 0, 0, 0, 8'h00, 8'h7C, 4'd5, 0));
        vecs.push_back(mk(1, 2'b10, 0, 0, 0, 8'h00, 8'hF8, 4'd6, 0));
        vecs.push_back(mk(1, 2'b10, 0, 0, 0, 8'h00, 8'hF0, 4'd7, 0));
        vecs.push_back(mk(1, 2'b10, 0, 0, 0, 8'h00, 8'hE0, 4'd8, 1));
        // done drops even with en=0; a saturated shift still moves the data.
        vecs.push_back(mk(0, 2'b01, 0, 1, 0, 8'h00, 8'hE0, 4'd8, 0));
        vecs.push_back(mk(1, 2'b01, 0, 1, 0, 8'h00, 8'hF0, 4'd8, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].mode, vecs[i].rot, vecs[i].sdi_r, vecs[i].sdi_l, vecs[i].din);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_cnt, vecs[i].exp_done);
        end

        // Reset arrives between edges after five of eight shifts.
        drive(1, 2'b11, 0, 0, 0, 8'hA5);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 2'b01, 0, 1, 0, 8'h00);
            tick();
        end
        check("mid.cnt_before", 32'(shift_cnt), 32'd5);
        #2 reset = 1'b1;
        #1;
        check_all("mid_reset", 8'h00, 4'd0, 1'b0);
        reset = 1'b0;
        tq = 8'h00;
        for (int i = 1; i <= 8; i++) begin
            drive(1, 2'b01, 0, 1, 0, 8'h00);
            tick();
            tq = (tq >> 1) | 8'h80;
            check_all($sformatf("post_reset%0d", i), tq, 4'(i), i == 8);
        end

        // Randomized traffic against the model, with occasional asynchronous resets.
        reset = 1'b1;
        #1 reset = 1'b0;
        m_q = 8'h00;
        m_shifts = 0;
        m_done = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                #2 reset = 1'b1;
                #1 reset = 1'b0;
                m_q = 8'h00;
                m_shifts = 0;
                m_done = 1'b0;
                check_all($sformatf("rnd_reset%0d", n), 8'h00, 4'd0, 1'b0);
            end
            re  = ($urandom_range(0, 9) != 0);
            sel = int'($urandom_range(0, 9));
            rm  = (sel == 0) ? 2'b00 : (sel <= 4) ? 2'b01 : (sel <= 8) ? 2'b10 : 2'b11;
            rr  = 1'($urandom_range(0, 3) == 0);
            rsr = 1'($urandom);
            rsl = 1'($urandom);
            rd  = 8'($urandom);
            drive(re, rm, rr, rsr, rsl, rd);
            tick();
            model_edge(re, rm, rr, rsr, rsl, rd);
            rq = m_q;
            check_all($sformatf("rnd%0d", n), rq, 4'((m_shifts > 8) ? 8 : m_shifts), m_done);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
